pid_output_processor: RTL and testbench

PID_OUTPUT_PROCESSOR -- requirements
Module: pid_output_processor

---
 rtl/pid_pkg.sv | 16 +
 rtl/pid_pwm_channel.sv | 124 ++++++++++++
 rtl/pid_output_processor.sv | 90 +++++++++
 tb/tb_pid_output_processor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared sizing constants and per-channel drive state encoding
// for the PID output processor.
package pid_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int NUM_CHN      = 4;
  localparam int CHN_WIDTH    = 3;
  localparam int RPM_MAX      = 1500;
  localparam int WDOG_PERIODS = 8;

  typedef enum logic {
    RUN   = 1'b0,
    BRAKE = 1'b1
  } chn_state_e;

endpackage

// File: rtl/pid_pwm_channel.sv
// One motor channel: pending command register, magnitude clamp, RUN/BRAKE
// reversal FSM, update watchdog and PWM compare against the shared counter.
module pid_pwm_channel #(
  parameter int DATA_WIDTH   = pid_pkg::DATA_WIDTH,
  parameter int RPM_MAX      = pid_pkg::RPM_MAX,
  parameter int WDOG_PERIODS = pid_pkg::WDOG_PERIODS,
  parameter int CNT_W        = $clog2(pid_pkg::RPM_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         boundary,
  input  logic                         wr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0]             counter,
  output logic                         pwm,
  output logic                         dir,
  output logic                         wdog
);

  localparam int WD_W = $clog2(WDOG_PERIODS + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_PERIODS);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WDOG_PERIODS - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(RPM_MAX);
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ABS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RPM_LIM = DATA_WIDTH'(RPM_MAX);

  // |v| saturated at the most negative code, then clamped to the PWM period.
  function automatic logic [CNT_W-1:0] clamp_mag(input logic signed [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] a;
    if (v == DATA_MIN) begin
      a = ABS_MAX;
    end else if (v[DATA_WIDTH-1]) begin
      a = DATA_WIDTH'(-v);
    end else begin
      a = v;
    end
    if (a > RPM_LIM) begin
      return DUTY_MAX;
    end
    return a[CNT_W-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] pending;
  logic [WD_W-1:0]              wd_cnt;
  logic                         sign;
  logic [CNT_W-1:0]             mag;
  pid_pkg::chn_state_e          state, state_nx;
  logic [CNT_W-1:0]             duty, duty_nx;
  logic                         dir_nx;

  assign sign = pending[DATA_WIDTH-1];
  assign mag  = clamp_mag(pending);

  // A write always beats a same-cycle watchdog expiry; the count saturates
  // so an expired channel stays expired until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      wd_cnt  <= '0;
      wdog    <= 1'b0;
    end else if (wr) begin
      pending <= wr_data;
      wd_cnt  <= '0;
      wdog    <= 1'b0;
    end else if (boundary && wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_LAST) begin
        pending <= '0;
        wdog    <= 1'b1;
      end
    end
  end

  // Boundary reload sees the pending value from before any same-edge write.
  always_comb begin
    state_nx = state;
    duty_nx  = duty;
    dir_nx   = dir;
    if (boundary) begin
      case (state)
        pid_pkg::RUN: begin
          if (sign != dir) begin
            state_nx = pid_pkg::BRAKE;
            duty_nx  = '0;
          end else begin
            duty_nx = mag;
          end
        end
        pid_pkg::BRAKE: begin
          state_nx = pid_pkg::RUN;
          dir_nx   = sign;
          duty_nx  = mag;
        end
        default: begin
          state_nx = pid_pkg::RUN;
          duty_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= pid_pkg::RUN;
      duty  <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nx;
      duty  <= duty_nx;
      dir   <= dir_nx;
    end
  end

  // Registered compare: output lags the counter by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= counter < duty;
    end
  end

endmodule

// File: rtl/pid_output_processor.sv
// PID result fan-out: channel decode, shared PWM period counter, frame
// completion tracking and bad-channel reporting around NUM_CHN channels.
module pid_output_processor #(
  parameter int DATA_WIDTH   = pid_pkg::DATA_WIDTH,
  parameter int NUM_CHN      = pid_pkg::NUM_CHN,
  parameter int CHN_WIDTH    = pid_pkg::CHN_WIDTH,
  parameter int RPM_MAX      = pid_pkg::RPM_MAX,
  parameter int WDOG_PERIODS = pid_pkg::WDOG_PERIODS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         res_valid_i,
  input  logic [CHN_WIDTH-1:0]         res_chn_i,
  input  logic signed [DATA_WIDTH-1:0] res_data_i,
  output logic [NUM_CHN-1:0]           pwm_o,
  output logic [NUM_CHN-1:0]           dir_o,
  output logic [NUM_CHN-1:0]           wdog_o,
  output logic                         frame_done_o,
  output logic                         chn_err_o
);

  localparam int CNT_W  = $clog2(RPM_MAX + 1);
  localparam int CHN_W1 = CHN_WIDTH + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RPM_MAX - 1);
  localparam logic [CHN_W1-1:0] CHN_LIMIT = CHN_W1'(NUM_CHN);

  logic [CNT_W-1:0]   counter;
  logic               boundary;
  logic               in_range_p0;
  logic               err_p0;
  logic [NUM_CHN-1:0] wr_p0;
  logic [NUM_CHN-1:0] mask;
  logic [NUM_CHN-1:0] mask_next;

  assign boundary = counter == CNT_LAST;

  always_ff @(posedge clk) begin
    if (rst || boundary) begin
      counter <= '0;
    end else begin
      counter <= counter + CNT_W'(1);
    end
  end

  // p0: decode the incoming beat into a one-hot channel write or an error.
  assign in_range_p0 = {1'b0, res_chn_i} < CHN_LIMIT;
  assign err_p0      = res_valid_i && !in_range_p0;

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
    assign wr_p0[g] = res_valid_i && in_range_p0 && (res_chn_i == CHN_WIDTH'(g));

    pid_pwm_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RPM_MAX     (RPM_MAX),
      .WDOG_PERIODS(WDOG_PERIODS),
      .CNT_W       (CNT_W)
    ) u_chn (
      .clk     (clk),
      .rst     (rst),
      .boundary(boundary),
      .wr      (wr_p0[g]),
      .wr_data (res_data_i),
      .counter (counter),
      .pwm     (pwm_o[g]),
      .dir     (dir_o[g]),
      .wdog    (wdog_o[g])
    );
  end

  assign mask_next = mask | wr_p0;

  // p1: registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask         <= '0;
      frame_done_o <= 1'b0;
      chn_err_o    <= 1'b0;
    end else begin
      chn_err_o <= err_p0;
      if (&mask_next) begin
        mask         <= '0;
        frame_done_o <= 1'b1;
      end else begin
        mask         <= mask_next;
        frame_done_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pid_output_processor.sv
// Directed bench for pid_output_processor: table of single-write cases from
// reset plus hand sequences for reversal, watchdog, frame and reset corners.
module tb_pid_output_processor;

  localparam int DATA_WIDTH   = 16;
  localparam int NUM_CHN      = 4;
  localparam int CHN_WIDTH    = 3;
  localparam int RPM_MAX      = 1500;
  localparam int WDOG_PERIODS = 8;
  localparam int NVEC         = 8;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         res_valid = 1'b0;
  logic [CHN_WIDTH-1:0]         res_chn = '0;
  logic signed [DATA_WIDTH-1:0] res_data = '0;
  logic [NUM_CHN-1:0]           pwm, dir, wdog;
  logic                         frame_done, chn_err;

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  int pcnt[NUM_CHN];
  logic [NUM_CHN-1:0] dir_s;

  typedef struct {
    int chn;
    int data;
    int wr_at;
    int d1;
    int r1;
    int d2;
    int r2;
  } vec_t;
  vec_t vecs[NVEC];
  int fseq[5];

  always #5 clk = ~clk;

  pid_output_processor #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CHN     (NUM_CHN),
    .CHN_WIDTH   (CHN_WIDTH),
    .RPM_MAX     (RPM_MAX),
    .WDOG_PERIODS(WDOG_PERIODS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid_i (res_valid),
    .res_chn_i   (res_chn),
    .res_data_i  (res_data),
    .pwm_o       (pwm),
    .dir_o       (dir),
    .wdog_o      (wdog),
    .frame_done_o(frame_done),
    .chn_err_o   (chn_err)
  );

  // Expected period counter position, independent of the DUT.
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (mcnt == RPM_MAX - 1) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write(input int chn, input int data);
    res_valid = 1'b1;
    res_chn   = CHN_WIDTH'(chn);
    res_data  = DATA_WIDTH'(data);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (mcnt != target && n < 2 * RPM_MAX) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mcnt != target) check("wait_cnt timeout", mcnt, target);
  endtask

  // Returns just after the edge on which the DUT takes its period boundary.
  task automatic wait_boundary;
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mcnt != 0 && n < 2 * RPM_MAX);
    if (mcnt != 0) check("wait_boundary timeout", mcnt, 0);
  endtask

  // Counts pwm highs over the period that starts at the last boundary edge.
  task automatic measure;
    for (int c = 0; c < NUM_CHN; c++) pcnt[c] = 0;
    for (int k = 0; k < RPM_MAX; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) dir_s = dir;
      for (int c = 0; c < NUM_CHN; c++) pcnt[c] += int'(pwm[c]);
    end
  endtask

  initial begin
    int nfd;
    vecs[0] = '{0,    750, 100,  750, 0,  750, 0};
    vecs[1] = '{1,   1500,   0, 1500, 0, 1500, 0};
    vecs[2] = '{2,   1501,   0, 1500, 0, 1500, 0};
    vecs[3] = '{3,      0,   0,    0, 0,    0, 0};
    vecs[4] = '{2, -32768,   0,    0, 0, 1500, 1};
    vecs[5] = '{0,     -1,   0,    0, 0,    1, 1};
    vecs[6] = '{1,  32767,   0, 1500, 0, 1500, 0};
    vecs[7] = '{3,  -1499,   0,    0, 0, 1499, 1};
    fseq = '{0, 1, 1, 2, 3};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset pwm", int'(pwm), 0);
    check("reset dir", int'(dir), 0);
    check("reset wdog", int'(wdog), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset chn_err", int'(chn_err), 0);
    rst = 1'b0;

    // table: single write from reset, two periods observed
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      wait_cnt(vecs[i].wr_at);
      write(vecs[i].chn, vecs[i].data);
      wait_boundary();
      measure();
      check($sformatf("vec%0d duty1", i), pcnt[vecs[i].chn], vecs[i].d1);
      check($sformatf("vec%0d dir1", i), int'(dir_s[vecs[i].chn]), vecs[i].r1);
      measure();
      check($sformatf("vec%0d duty2", i), pcnt[vecs[i].chn], vecs[i].d2);
      check($sformatf("vec%0d dir2", i), int'(dir_s[vecs[i].chn]), vecs[i].r2);
    end

    // reversal: +600 then -2000 brakes one period before reversing
    do_reset();
    write(1, 600);
    wait_boundary();
    measure();
    check("rev fwd duty", pcnt[1], 600);
    check("rev fwd dir", int'(dir_s[1]), 0);
    write(1, -2000);
    wait_boundary();
    measure();
    check("rev brake duty", pcnt[1], 0);
    check("rev brake dir", int'(dir_s[1]), 0);
    measure();
    check("rev new duty", pcnt[1], 1500);
    check("rev new dir", int'(dir_s[1]), 1);

    // watchdog on ch3; ch2 rewritten on the expiry boundary
    do_reset();
    write(3, 300);
    write(2, 400);
    repeat (7) wait_boundary();
    check("wdog3 before expiry", int'(wdog[3]), 0);
    check("wdog2 before expiry", int'(wdog[2]), 0);
    wait_cnt(RPM_MAX - 1);
    write(2, 800);
    check("wdog3 expired", int'(wdog[3]), 1);
    check("wdog2 write wins", int'(wdog[2]), 0);
    measure();
    check("wdog3 last period duty", pcnt[3], 300);
    check("wdog2 old duty", pcnt[2], 400);
    measure();
    check("wdog3 forced zero", pcnt[3], 0);
    check("wdog2 new duty", pcnt[2], 800);
    check("wdog3 still set", int'(wdog[3]), 1);
    write(3, 300);
    check("wdog3 cleared", int'(wdog[3]), 0);
    wait_boundary();
    measure();
    check("wdog3 duty back", pcnt[3], 300);

    // frame completion and out-of-range channels
    do_reset();
    nfd = 0;
    for (int k = 0; k < 5; k++) begin
      write(fseq[k], 0);
      check($sformatf("frame_done after write %0d", k), int'(frame_done), (k == 4) ? 1 : 0);
      check($sformatf("chn_err after write %0d", k), int'(chn_err), 0);
      nfd += int'(frame_done);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      nfd += int'(frame_done);
    end
    check("frame_done pulse count", nfd, 1);
    write(5, 1000);
    check("chn_err chn5", int'(chn_err), 1);
    write(4, 1000);
    check("chn_err chn4", int'(chn_err), 1);
    @(posedge clk);
    #1;
    check("chn_err clears", int'(chn_err), 0);
    check("no frame_done from bad chn", int'(frame_done), 0);
    wait_boundary();
    measure();
    for (int c = 0; c < NUM_CHN; c++)
      check($sformatf("bad chn leaves ch%0d idle", c), pcnt[c], 0);
    check("bad chn dir", int'(dir), 0);
    check("bad chn wdog", int'(wdog), 0);

    // write on the boundary cycle, then reset mid-period
    do_reset();
    write(0, 500);
    wait_boundary();
    wait_cnt(RPM_MAX - 1);
    write(0, 100);
    measure();
    check("boundary write old duty", pcnt[0], 500);
    measure();
    check("boundary write new duty", pcnt[0], 100);
    wait_cnt(50);
    check("pwm0 high before reset", int'(pwm[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset pwm", int'(pwm), 0);
    check("mid reset dir", int'(dir), 0);
    check("mid reset wdog", int'(wdog), 0);
    check("mid reset pulses", int'({frame_done, chn_err}), 0);
    rst = 1'b0;
    nfd = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      nfd += int'(pwm[0]);
    end
    check("pwm0 idle after reset", nfd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
